// File: rtl/joy_db15_pkg.sv
// Shared constants and types for the DB15 joystick adapter transmitter model.
package joy_db15_pkg;

  localparam int JOY_WIDTH = 16;

  // Active-high word layout, LSB first: R L D U A B C D E F, then start/select/coin.
  localparam int JOY_BIT_R      = 0;
  localparam int JOY_BIT_L      = 1;
  localparam int JOY_BIT_DN     = 2;
  localparam int JOY_BIT_UP     = 3;
  localparam int JOY_BIT_A      = 4;
  localparam int JOY_BIT_B      = 5;
  localparam int JOY_BIT_C      = 6;
  localparam int JOY_BIT_D      = 7;
  localparam int JOY_BIT_E      = 8;
  localparam int JOY_BIT_F      = 9;
  localparam int JOY_BIT_START  = 10;
  localparam int JOY_BIT_SELECT = 11;
  localparam int JOY_BIT_COIN   = 12;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} joy_tx_state_t;

endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// Two-flop synchronizer with a rising-edge strobe; idles high so a released line is quiet.
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/joy_db15_tx.sv
// Device-side DB15 adapter model: snapshots two player words on load and
// shifts them LSB-first, active-low, one bit per synchronized joy_clk edge.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int WIDTH   = JOY_WIDTH,
  parameter int PLAYERS = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             joy_clk,
  input  logic             joy_load,
  output logic             joy_data,
  input  logic [WIDTH-1:0] joystick1,
  input  logic [WIDTH-1:0] joystick2,
  output logic             frame_done,
  output logic             overrun
);

  localparam int N  = WIDTH * PLAYERS;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_PRELAST = CW'(N - 2);
  localparam logic [CW-1:0] CNT_LAST    = CW'(N - 1);

  logic          joy_clk_unused, clk_rise;
  logic          load_s, load_rise;
  joy_tx_state_t state;
  logic [N-1:0]  sr, snap;
  logic [CW-1:0] cnt;
  logic          last_pend;

  sync_edge u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (joy_clk),
    .q       (joy_clk_unused),
    .rise    (clk_rise)
  );

  sync_edge u_load_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (joy_load),
    .q       (load_s),
    .rise    (load_rise)
  );

  // Unused upper player slots read as released (1 on the line).
  assign snap = ~(N'({joystick2, joystick1}));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sr         <= '1;
      cnt        <= '0;
      overrun    <= 1'b0;
      last_pend  <= 1'b0;
      frame_done <= 1'b0;
      joy_data   <= 1'b1;
    end else begin
      last_pend  <= 1'b0;
      // frame_done lines up with the output register that presents the last bit.
      frame_done <= last_pend;
      joy_data   <= (state == LOAD || state == SHIFT) ? sr[0] : 1'b1;
      if (!load_s) begin
        // Load dominates any coincident shift edge and aborts a frame in progress.
        state   <= LOAD;
        sr      <= snap;
        cnt     <= '0;
        overrun <= 1'b0;
      end else begin
        case (state)
          LOAD: if (load_rise) state <= SHIFT;
          SHIFT: if (clk_rise) begin
            sr  <= {1'b1, sr[N-1:1]};
            cnt <= cnt + CW'(1);
            if (cnt == CNT_PRELAST) last_pend <= 1'b1;
            if (cnt == CNT_LAST) state <= DONE;
          end
          DONE: if (clk_rise) overrun <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
